// File: rtl/instr_encode.sv
// LEGv8 instruction encoder: op + fields in, 32-bit word + sequential slot address out.
// One-cycle latency, full throughput; stalls input while a word is held and not taken, or when all slots are issued.
module instr_encode #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_ORR  = 4'd3;
    localparam logic [3:0] OP_LDUR = 4'd4;
    localparam logic [3:0] OP_STUR = 4'd5;
    localparam logic [3:0] OP_CBZ  = 4'd6;
    localparam logic [3:0] OP_B    = 4'd7;
    localparam logic [3:0] OP_MOVK = 4'd8;

    logic [ADDR_W:0]   count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [31:0] word;
    logic        illegal;
    logic        range_bad;
    logic        accept;

    // A signed immediate fits when every bit above the field's sign bit equals it.
    logic fits_d9, fits_d16, fits_b21, fits_u16;
    assign fits_d9  = (&in_imm[63:10]) | ~(|in_imm[63:10]);
    assign fits_d16 = (&in_imm[63:15]) | ~(|in_imm[63:15]);
    assign fits_b21 = (&in_imm[63:20]) | ~(|in_imm[63:20]);
    assign fits_u16 = ~(|in_imm[63:16]);

    always_comb begin
        word      = 32'd0;
        illegal   = 1'b0;
        range_bad = 1'b0;
        case (in_op)
            OP_ADD:  word = {11'h458, in_rm, 6'd0, in_rn, in_rd};
            OP_SUB:  word = {11'h658, in_rm, 6'd0, in_rn, in_rd};
            OP_AND:  word = {11'h450, in_rm, 6'd0, in_rn, in_rd};
            OP_ORR:  word = {11'h550, in_rm, 6'd0, in_rn, in_rd};
            OP_LDUR: begin
                word      = {11'h7C2, in_imm[10:0], in_rn, in_rd};
                range_bad = ~fits_d9;
            end
            OP_STUR: begin
                word      = {11'h7C0, in_imm[10:0], in_rn, in_rd};
                range_bad = ~fits_d9;
            end
            OP_CBZ: begin
                word      = {11'h5A0, in_imm[15:0], in_rd};
                range_bad = ~fits_d16;
            end
            OP_B: begin
                word      = {11'h0A0, in_imm[20:0]};
                range_bad = ~fits_b21;
            end
            OP_MOVK: begin
                word      = {11'h794, in_imm[15:0], in_rd};
                range_bad = ~fits_u16;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign full     = (count_q == DEPTH_C);
    assign in_ready = ~full & (~out_valid_q | out_ready) & ~clear;
    assign accept   = in_valid & in_ready;

    always_comb begin
        count_d     = count_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        err_valid_d = 1'b0;
        err_code_d  = 2'd0;
        if (clear) begin
            count_d     = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            if (illegal) begin
                err_valid_d = 1'b1;
                err_code_d  = 2'd1;
            end else if (range_bad) begin
                err_valid_d = 1'b1;
                err_code_d  = 2'd2;
            end else begin
                // A transfer in the same cycle frees the slot, so the new word replaces it without a bubble.
                out_valid_d = 1'b1;
                out_instr_d = word;
                out_addr_d  = count_q[ADDR_W-1:0];
                count_d     = count_q + ONE_C;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_addr_q  <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encode.sv
// Bench for instr_encode: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_instr_encode;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [63:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_valid;
    logic [1:0]        err_code;
    logic              full;
    logic [ADDR_W:0]   count;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: what the spec says the outputs should be after each edge.
    int          m_count;
    bit          m_ov;
    logic [31:0] m_instr;
    int          m_addr;
    bit          m_err;
    int          m_code;

    instr_encode #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_valid(err_valid), .err_code(err_code),
        .full(full), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint wrap(input longint v, input int bits);
        longint m;
        m = longint'(1) << bits;
        return ((v % m) + m) % m;
    endfunction

    function automatic void ref_encode(input int op, input int rd, input int rn, input int rm,
                                       input longint imm, output logic [31:0] w, output int code);
        longint r;
        longint opc [9];
        opc = '{64'h458, 64'h658, 64'h450, 64'h550, 64'h7C2, 64'h7C0, 64'h5A0, 64'h0A0, 64'h794};
        r = 0;
        code = 0;
        if (op > 8) code = 1;
        else if (op <= 3) r = opc[op] * 2097152 + rm * 65536 + rn * 32 + rd;
        else if (op <= 5) begin
            if (imm < -1024 || imm > 1023) code = 2;
            else r = opc[op] * 2097152 + wrap(imm, 11) * 1024 + rn * 32 + rd;
        end else if (op == 6) begin
            if (imm < -32768 || imm > 32767) code = 2;
            else r = opc[op] * 2097152 + wrap(imm, 16) * 32 + rd;
        end else if (op == 7) begin
            if (imm < -1048576 || imm > 1048575) code = 2;
            else r = opc[op] * 2097152 + wrap(imm, 21);
        end else begin
            if (imm < 0 || imm > 65535) code = 2;
            else r = opc[op] * 2097152 + imm * 32 + rd;
        end
        w = 32'(r);
    endfunction

    function automatic bit model_ready();
        return (m_count != DEPTH) && (!m_ov || out_ready) && !clear;
    endfunction

    task automatic model_reset();
        m_count = 0; m_ov = 0; m_instr = 0; m_addr = 0; m_err = 0; m_code = 0;
    endtask

    // Advance one clock: evaluate the model on the inputs seen at the edge, then land on the next falling edge.
    task automatic cycle();
        logic [31:0] w;
        int          c;
        bit          rdy;
        int          n_count, n_addr, n_code;
        bit          n_ov, n_err;
        logic [31:0] n_instr;
        rdy     = model_ready();
        n_count = m_count; n_ov = m_ov && !out_ready; n_instr = m_instr; n_addr = m_addr;
        n_err   = 0; n_code = 0;
        if (clear) begin
            n_count = 0; n_ov = 0;
        end else if (in_valid && rdy) begin
            ref_encode(int'(in_op), int'(in_rd), int'(in_rn), int'(in_rm), longint'(in_imm), w, c);
            if (c == 0) begin
                n_ov = 1; n_instr = w; n_addr = m_count; n_count = m_count + 1;
            end else begin
                n_err = 1; n_code = c;
            end
        end
        @(posedge clk);
        m_count = n_count; m_ov = n_ov; m_instr = n_instr; m_addr = n_addr; m_err = n_err; m_code = n_code;
        @(negedge clk);
    endtask

    task automatic set_req(input int op, input int rd, input int rn, input int rm, input longint imm);
        in_valid = 1'b1;
        in_op = 4'(op); in_rd = 5'(rd); in_rn = 5'(rn); in_rm = 5'(rm); in_imm = imm;
    endtask

    task automatic do_clear();
        in_valid = 1'b0; clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 0; in_rd = 0; in_rn = 0; in_rm = 0; in_imm = 0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, out_instr, out_addr, err_valid, err_code, count, full} !== '0) begin
            n_err++;
            $display("FAIL reset_values got ov=%b instr=%h addr=%0d err=%b code=%0d count=%0d full=%b want all zero",
                     out_valid, out_instr, out_addr, err_valid, err_code, count, full);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_add();
        set_req(0, 1, 2, 3, 0);
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h8B030041 || out_addr !== 0 || count !== 1) begin
            n_err++;
            $display("FAIL add got ov=%b instr=%h addr=%0d count=%0d want ov=1 instr=8b030041 addr=0 count=1",
                     out_valid, out_instr, out_addr, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4];
        exp_w = '{32'hF84020C5, 32'h141FFFFC, 32'hB41FFFE9, 32'hF2824687};
        do_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_req(4, 5, 6, 0, 8);
                1: set_req(7, 0, 0, 0, -4);
                2: set_req(6, 9, 0, 0, -1);
                default: set_req(8, 7, 0, 0, 64'h1234);
            endcase
            cycle();
            n_checks++;
            if (out_valid !== 1'b1 || out_instr !== exp_w[i] || out_addr !== ADDR_W'(i)) begin
                n_err++;
                $display("FAIL b2b_%0d got ov=%b instr=%h addr=%0d want ov=1 instr=%h addr=%0d",
                         i, out_valid, out_instr, out_addr, exp_w[i], i);
            end
        end
        set_req(0, 1, 2, 3, 0);
        #1;
        n_checks++;
        if (full !== 1'b1 || count !== 4 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL depth_full got full=%b count=%0d in_ready=%b want full=1 count=4 in_ready=0",
                     full, count, in_ready);
        end
        repeat (2) cycle();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 4) begin
            n_err++;
            $display("FAIL depth_stall got ov=%b count=%0d want ov=0 count=4", out_valid, count);
        end
        clear = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL clear_blocks got in_ready=%b want 0", in_ready); end
        cycle();
        clear = 1'b0;
        #1;
        n_checks++;
        if (count !== 0 || full !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL clear_state got count=%0d full=%b ov=%b in_ready=%b want 0 0 0 1",
                     count, full, out_valid, in_ready);
        end
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_addr !== 0 || out_instr !== 32'h8B030041 || count !== 1) begin
            n_err++;
            $display("FAIL fifth_after_clear got ov=%b addr=%0d instr=%h count=%0d want 1 0 8b030041 1",
                     out_valid, out_addr, out_instr, count);
        end
    endtask

    task automatic test_stall();
        do_clear();
        out_ready = 1'b1;
        set_req(0, 1, 2, 3, 0);
        cycle();
        out_ready = 1'b0;
        set_req(4, 5, 6, 0, 8);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h8B030041 || out_addr !== 0) begin
                n_err++;
                $display("FAIL stall_%0d got in_ready=%b ov=%b instr=%h addr=%0d want 0 1 8b030041 0",
                         i, in_ready, out_valid, out_instr, out_addr);
            end
            cycle();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got=%b want=1", in_ready); end
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'hF84020C5 || out_addr !== 1) begin
            n_err++;
            $display("FAIL stall_queued got ov=%b instr=%h addr=%0d want 1 f84020c5 1", out_valid, out_instr, out_addr);
        end
        cycle();
    endtask

    task automatic test_errors();
        int     ops  [3];
        longint imms [3];
        int     codes[3];
        ops = '{12, 4, 8}; imms = '{0, 1024, -1}; codes = '{1, 2, 2};
        do_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(ops[i], 3, 4, 5, imms[i]);
            cycle();
            in_valid = 1'b0;
            n_checks++;
            if (err_valid !== 1'b1 || err_code !== 2'(codes[i]) || out_valid !== 1'b0 || count !== 0) begin
                n_err++;
                $display("FAIL err_%0d got err=%b code=%0d ov=%b count=%0d want 1 %0d 0 0",
                         i, err_valid, err_code, out_valid, count, codes[i]);
            end
            cycle();
            n_checks++;
            if (err_valid !== 1'b0 || err_code !== 2'd0) begin
                n_err++;
                $display("FAIL err_pulse_%0d got err=%b code=%0d want 0 0", i, err_valid, err_code);
            end
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        out_ready = 1'b0;
        set_req(1, 4, 5, 6, 0);
        cycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 0 || out_instr !== 0) begin
            n_err++;
            $display("FAIL async_reset got ov=%b count=%0d instr=%h want 0 0 0", out_valid, count, out_instr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_req(0, 1, 2, 3, 0);
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_addr !== 0 || out_instr !== 32'h8B030041) begin
            n_err++;
            $display("FAIL after_reset_add got ov=%b addr=%0d instr=%h want 1 0 8b030041", out_valid, out_addr, out_instr);
        end
    endtask

    function automatic longint pick_imm();
        longint bnd [16];
        bnd = '{-1048577, -1048576, -32769, -32768, -1025, -1024, -1, 0,
                1023, 1024, 32767, 32768, 65535, 65536, 1048575, 1048576};
        case ($urandom_range(0, 2))
            0:       return bnd[$urandom_range(0, 15)];
            1:       return longint'($signed($urandom)) >>> $urandom_range(0, 31);
            default: return longint'({$urandom, $urandom});
        endcase
    endfunction

    task automatic test_random();
        bit exp_rdy;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            clear     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            in_rd     = 5'($urandom);
            in_rn     = 5'($urandom);
            in_rm     = 5'($urandom);
            in_imm    = pick_imm();
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = model_ready();
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_err++; bad++;
                if (bad < 10) $display("FAIL rand_ready it=%0d got=%b want=%b", i, in_ready, exp_rdy);
            end
            cycle();
            n_checks++;
            if (out_valid !== m_ov || err_valid !== m_err || err_code !== 2'(m_code) ||
                count !== (ADDR_W+1)'(m_count) || full !== (m_count == DEPTH) ||
                (m_ov && (out_instr !== m_instr || out_addr !== ADDR_W'(m_addr)))) begin
                n_err++; bad++;
                if (bad < 10)
                    $display("FAIL rand_out it=%0d got ov=%b instr=%h addr=%0d err=%b code=%0d count=%0d want ov=%b instr=%h addr=%0d err=%b code=%0d count=%0d",
                             i, out_valid, out_instr, out_addr, err_valid, err_code, count,
                             m_ov, m_instr, m_addr, m_err, m_code, m_count);
            end
        end
        clear = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_errors();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encode.md
Name: instr_encode

Overview:
- Pipelined LEGv8 instruction encoder; the inverse of the datapath's instruction field parser.
- Accepts an operation plus register/immediate fields over a valid/ready handshake and emits the 32-bit instruction word with a sequential instruction-memory write address.
- Used by the test harness and boot loader to fill instruction memory.
- Every legal word it produces must round-trip exactly through the datapath's field parser.

Parameters:
- ADDR_W, 8, width of the emitted write address (word index).
- DEPTH, 256, number of instruction slots; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous; resets the address counter and drops any held output.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 B, 8 MOVK; 9-15 illegal.
- in_rd  in  5  Rd (R-format, MOVK, LDUR) or Rt (STUR, CBZ).
- in_rn  in  5  Rn (R-format, LDUR, STUR).
- in_rm  in  5  Rm (R-format).
- in_imm  in  64  signed immediate (unsigned for MOVK).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  slot index for out_instr.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  1 = illegal op, 2 = immediate out of range; 0 when err_valid is low.
- full  out  1  all DEPTH slots issued.
- count  out  ADDR_W+1  number of legal words issued since reset/clear.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - out_valid=0, out_instr=0, out_addr=0, err_valid=0, err_code=0, count=0, full=0.
  - in_ready goes high in the first cycle after reset deassertion.
- Handshake:
  - in_ready = !full && (!out_valid || out_ready) && !clear.
  - A request is accepted when in_valid && in_ready on a rising edge.
  - Output transfer occurs when out_valid && out_ready.
  - out_instr and out_addr hold stable while out_valid && !out_ready.
- Latency: a legal accepted request raises out_valid on the next edge. Throughput is one word per cycle when out_ready is held high.
- Encoding (opcode in [31:21]):
  - ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550: [20:16]=Rm, [15:10]=0, [9:5]=Rn, [4:0]=Rd. in_imm is ignored.
  - LDUR 0x7C2, STUR 0x7C0: [20:10]=imm[10:0], [9:5]=Rn, [4:0]=Rt. Legal range is -1024..1023.
  - CBZ 0x5A0: [20:5]=imm[15:0], [4:0]=Rt. Legal range is -32768..32767.
  - B 0x0A0: [20:0]=imm[20:0]. Legal range is -1048576..1048575.
  - MOVK 0x794: [20:5]=imm[15:0], [4:0]=Rd. Legal range is 0..65535.
- Range check: the check is on the full 64-bit in_imm. Signed ops check that the bits above the field's sign bit are all equal to the sign bit.
- Errors:
  - An illegal op or out-of-range immediate is still accepted (handshake completes).
  - No word is emitted and count/address do not advance.
  - err_valid pulses for exactly one cycle on the next edge, with err_code 1 or 2. Illegal op takes priority over range.
  - out_valid and its held word are unaffected by the error.
- Address and count:
  - On a legal accept, out_addr <= count[ADDR_W-1:0] and count increments.
  - full = (count == DEPTH).
  - When full, in_ready=0. The word already held completes its transfer normally.
  - There is no wrap-around.
- clear:
  - Sets count=0, full=0, out_valid=0 and err_valid=0 on the next edge.
  - Any request presented in the same cycle is not accepted (in_ready=0).
- Reset mid-operation: async assertion immediately forces all reset values; a held word is discarded.
- Simultaneous output transfer and new accept in the same cycle: the new word replaces the old one with no bubble.

Test Plan:
- ADD rd=1 rn=2 rm=3, out_ready=1 -> next cycle out_valid=1, out_instr=0x8B030041, out_addr=0, count=1.
- Back-to-back LDUR rd=5 rn=6 imm=8, then B imm=-4, then CBZ rd=9 imm=-1, then MOVK rd=7 imm=0x1234 -> out_instr 0xF84020C5, 0x141FFFFC, 0xB41FFFE9, 0xF2824687 on consecutive cycles; out_addr 0,1,2,3.
- out_ready=0 for 3 cycles with a word held and in_valid=1 -> in_ready=0, out_instr/out_addr stable; one cycle after out_ready rises the queued word appears.
- in_op=12; then LDUR imm=1024; then MOVK imm=-1 -> err_valid pulses with err_code 1, 2, 2 respectively; count unchanged, out_valid never set.
- DEPTH=4, five legal requests -> addrs 0..3, full=1 after the 4th accept, 5th stalls (in_ready=0); clear -> count=0, full=0, the 5th is then accepted with out_addr=0.
- rst_n pulled low while out_valid=1 with out_ready=0 -> out_valid=0 and count=0 immediately (asynchronously); after release, the next ADD gets out_addr=0.
